// File: rtl/pipeline_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_pkg
// Shared definitions for the MIPS32 pipeline stall/flush control:
//   - multiply/divide sequencer state encoding
//   - default multiply/divide occupancy (cycles)
//   - bit positions of the stall/flush control bundle, also used by the
//     pipeline register modules that consume these controls
//   - load-use hazard detection helper
// ---------------------------------------------------------------------------
package pipeline_ctrl_pkg;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } muldiv_state_t;

  localparam int DEF_MUL_CYCLES = 4;
  localparam int DEF_DIV_CYCLES = 32;

  // Control bundle layout
  localparam int CTRL_PC_WRITE    = 0;
  localparam int CTRL_IF_ID_WRITE = 1;
  localparam int CTRL_ID_EX_BUBBLE = 2;
  localparam int CTRL_IF_ID_FLUSH = 3;
  localparam int CTRL_W           = 4;

  // Canonical bundle values: {flush, bubble, if_id_write, pc_write}
  localparam logic [CTRL_W-1:0] CTRL_NORMAL = 4'b0011;
  localparam logic [CTRL_W-1:0] CTRL_STALL  = 4'b0100;
  localparam logic [CTRL_W-1:0] CTRL_FLUSH  = 4'b1111;

  // A load in EX whose destination is read by the instruction in ID.
  // $0 is never a real dependency; rt only counts when ID actually reads it.
  function automatic logic load_use_hazard(
    input logic       ex_mem_read,
    input logic [4:0] ex_rt,
    input logic [4:0] id_rs,
    input logic [4:0] id_rt,
    input logic       id_uses_rt
  );
    return ex_mem_read & (ex_rt != 5'd0) &
           ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
  endfunction

endpackage

// File: rtl/muldiv_seq.sv
// ---------------------------------------------------------------------------
// muldiv_seq
// Occupancy sequencer for the multi-cycle multiply/divide unit.
// An accepted start in cycle T keeps the unit busy for T+1..T+N
// (N = MUL_CYCLES or DIV_CYCLES); hilo_we is raised in T+N.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   start        mult/div in EX this cycle (ignored while busy)
//   is_div       1 = div/divu, 0 = mult/multu
//   busy         unit computing (registered)
//   hilo_we      write HI/LO this cycle (registered)
//   count_nz     remaining count is non-zero (result not yet available)
// ---------------------------------------------------------------------------
module muldiv_seq
  import pipeline_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = DEF_MUL_CYCLES,
  parameter int DIV_CYCLES = DEF_DIV_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic is_div,
  output logic busy,
  output logic hilo_we,
  output logic count_nz
);

  localparam int CNT_W = $clog2(DIV_CYCLES);

  muldiv_state_t    state_r, state_nxt_s;
  logic [CNT_W-1:0] count_r, count_nxt_s;
  logic             hilo_we_r;

  // Next-state and counter decode
  always_comb begin
    state_nxt_s = state_r;
    count_nxt_s = count_r;
    case (state_r)
      MD_IDLE: begin
        if (start) begin
          count_nxt_s = is_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);
          state_nxt_s = MD_BUSY;
        end else begin
          state_nxt_s = MD_IDLE;
        end
      end
      MD_BUSY: begin
        // A start while busy cannot be legal (ID stalls HiLo users), and one
        // coinciding with the final cycle is dropped as well.
        if (count_r != '0) begin
          count_nxt_s = count_r - CNT_W'(1);
        end else begin
          state_nxt_s = MD_IDLE;
        end
      end
      default: begin
        state_nxt_s = MD_IDLE;
        count_nxt_s = '0;
      end
    endcase
  end

  // State, counter and write-strobe registers; the strobe is precomputed so
  // it lands in the last BUSY cycle (count reaching zero).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= MD_IDLE;
      count_r   <= '0;
      hilo_we_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      count_r   <= count_nxt_s;
      hilo_we_r <= (state_nxt_s == MD_BUSY) && (count_nxt_s == '0);
    end
  end

  assign busy     = (state_r == MD_BUSY);
  assign hilo_we  = hilo_we_r;
  assign count_nz = (count_r != '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Stall/flush sequencer for the 5-stage MIPS32 pipeline. Covers the hazards
// forwarding cannot: load-use bubble, EX-resolved branch/jump redirect, and
// the multi-cycle multiply/divide unit.
// Build option: MULDIV_STALL_EN - when defined, the multiply/divide sequencer
// and HI/LO stall are built; otherwise MulDiv_Busy/HiLo_We are tied low and
// the muldiv inputs are ignored (single-cycle multiplier build).
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   ID_EX_MemRead, ID_EX_Reg_Rt  load in EX and its destination
//   IF_ID_Reg_Rs/Rt, UsesRt      source registers of the ID instruction
//   IF_ID_UsesHiLo               ID instruction uses HI/LO or the unit
//   MulDiv_Start_EX, IsDiv_EX    mult/div issuing from EX
//   Branch_Taken_EX              redirect from EX
//   PC_Write, IF_ID_Write        stage enables
//   ID_EX_Bubble, IF_ID_Flush    nop insertion / IF/ID clear
//   MulDiv_Busy, HiLo_We         unit status and HI/LO write strobe
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = DEF_MUL_CYCLES,
  parameter int DIV_CYCLES = DEF_DIV_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ID_EX_MemRead,
  input  logic [4:0] ID_EX_Reg_Rt,
  input  logic [4:0] IF_ID_Reg_Rs,
  input  logic [4:0] IF_ID_Reg_Rt,
  input  logic       IF_ID_UsesRt,
  input  logic       IF_ID_UsesHiLo,
  input  logic       MulDiv_Start_EX,
  input  logic       MulDiv_IsDiv_EX,
  input  logic       Branch_Taken_EX,
  output logic       PC_Write,
  output logic       IF_ID_Write,
  output logic       ID_EX_Bubble,
  output logic       IF_ID_Flush,
  output logic       MulDiv_Busy,
  output logic       HiLo_We
);

  logic              load_use_s;
  logic              hilo_stall_s;
  logic [CTRL_W-1:0] ctrl_s;

  assign load_use_s = load_use_hazard(ID_EX_MemRead, ID_EX_Reg_Rt,
                                      IF_ID_Reg_Rs, IF_ID_Reg_Rt, IF_ID_UsesRt);

`ifdef MULDIV_STALL_EN
  logic busy_s;
  logic hilo_we_s;
  logic count_nz_s;

  muldiv_seq #(
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_muldiv_seq (
    .clk      (clk),
    .rst      (rst),
    .start    (MulDiv_Start_EX),
    .is_div   (MulDiv_IsDiv_EX),
    .busy     (busy_s),
    .hilo_we  (hilo_we_s),
    .count_nz (count_nz_s)
  );

  // Release the HiLo user in the write cycle so it reaches EX right after.
  assign hilo_stall_s = busy_s & count_nz_s & IF_ID_UsesHiLo;
  assign MulDiv_Busy  = busy_s;
  assign HiLo_We      = hilo_we_s;
`else
  logic unused_muldiv_s;

  assign unused_muldiv_s = ^{MulDiv_Start_EX, MulDiv_IsDiv_EX, IF_ID_UsesHiLo,
                             (MUL_CYCLES > DIV_CYCLES)};
  assign hilo_stall_s    = 1'b0;
  assign MulDiv_Busy     = 1'b0;
  assign HiLo_We         = 1'b0;
`endif

  // Hazard priority: flush beats any stall since the stalled instruction is
  // discarded anyway; reset forces the free-running values.
  always_comb begin
    ctrl_s = CTRL_NORMAL;
    if (rst) begin
      ctrl_s = CTRL_NORMAL;
    end else if (Branch_Taken_EX) begin
      ctrl_s = CTRL_FLUSH;
    end else if (load_use_s | hilo_stall_s) begin
      ctrl_s = CTRL_STALL;
    end else begin
      ctrl_s = CTRL_NORMAL;
    end
  end

  assign PC_Write     = ctrl_s[CTRL_PC_WRITE];
  assign IF_ID_Write  = ctrl_s[CTRL_IF_ID_WRITE];
  assign ID_EX_Bubble = ctrl_s[CTRL_ID_EX_BUBBLE];
  assign IF_ID_Flush  = ctrl_s[CTRL_IF_ID_FLUSH];

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Directed bench for pipeline_hazard_ctrl (MUL_CYCLES=4, DIV_CYCLES=32).
// Observed vector: {PC_Write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush,
//                   MulDiv_Busy, HiLo_We}.
// Muldiv expectations follow the MULDIV_STALL_EN build option.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

`ifdef MULDIV_STALL_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  localparam logic [5:0] E_NORMAL     = 6'b110000;
  localparam logic [5:0] E_STALL      = 6'b001000;
  localparam logic [5:0] E_FLUSH      = 6'b111100;
  localparam logic [5:0] E_BUSY_STALL = 6'b001010;
  localparam logic [5:0] E_BUSY_RUN   = 6'b110010;
  localparam logic [5:0] E_BUSY_FLUSH = 6'b111110;
  localparam logic [5:0] E_BUSY_WE    = 6'b110011;

  logic       clk = 1'b0;
  logic       rst;
  logic       ID_EX_MemRead;
  logic [4:0] ID_EX_Reg_Rt;
  logic [4:0] IF_ID_Reg_Rs;
  logic [4:0] IF_ID_Reg_Rt;
  logic       IF_ID_UsesRt;
  logic       IF_ID_UsesHiLo;
  logic       MulDiv_Start_EX;
  logic       MulDiv_IsDiv_EX;
  logic       Branch_Taken_EX;
  logic       PC_Write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, MulDiv_Busy, HiLo_We;

  int checks = 0;
  int errors = 0;
  int pulses;

  pipeline_hazard_ctrl #(.MUL_CYCLES(4), .DIV_CYCLES(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .ID_EX_MemRead   (ID_EX_MemRead),
    .ID_EX_Reg_Rt    (ID_EX_Reg_Rt),
    .IF_ID_Reg_Rs    (IF_ID_Reg_Rs),
    .IF_ID_Reg_Rt    (IF_ID_Reg_Rt),
    .IF_ID_UsesRt    (IF_ID_UsesRt),
    .IF_ID_UsesHiLo  (IF_ID_UsesHiLo),
    .MulDiv_Start_EX (MulDiv_Start_EX),
    .MulDiv_IsDiv_EX (MulDiv_IsDiv_EX),
    .Branch_Taken_EX (Branch_Taken_EX),
    .PC_Write        (PC_Write),
    .IF_ID_Write     (IF_ID_Write),
    .ID_EX_Bubble    (ID_EX_Bubble),
    .IF_ID_Flush     (IF_ID_Flush),
    .MulDiv_Busy     (MulDiv_Busy),
    .HiLo_We         (HiLo_We)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] pick(input logic [5:0] en_val, input logic [5:0] dis_val);
    return MD_EN ? en_val : dis_val;
  endfunction

  task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [5:0] exp);
    chk(tag, {PC_Write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, MulDiv_Busy, HiLo_We}, exp);
  endtask

  // Advance to the next cycle; inputs are then applied 2 time units past the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    ID_EX_MemRead   = 1'b0;
    ID_EX_Reg_Rt    = 5'd0;
    IF_ID_Reg_Rs    = 5'd0;
    IF_ID_Reg_Rt    = 5'd0;
    IF_ID_UsesRt    = 1'b0;
    IF_ID_UsesHiLo  = 1'b0;
    MulDiv_Start_EX = 1'b0;
    MulDiv_IsDiv_EX = 1'b0;
    Branch_Taken_EX = 1'b0;
  endtask

  // Mult started in the current cycle T with a HiLo user waiting in ID;
  // a branch in T+2 must flush but not abort the unit.
  task automatic run_mult(input string tag);
    MulDiv_Start_EX = 1'b1; MulDiv_IsDiv_EX = 1'b0; IF_ID_UsesHiLo = 1'b1;
    #1 chk_out({tag, "_t0"}, E_NORMAL);
    tick(); MulDiv_Start_EX = 1'b0;
    #1 chk_out({tag, "_t1"}, pick(E_BUSY_STALL, E_NORMAL));
    tick(); Branch_Taken_EX = 1'b1;
    #1 chk_out({tag, "_t2_flush"}, pick(E_BUSY_FLUSH, E_FLUSH));
    tick(); Branch_Taken_EX = 1'b0;
    #1 chk_out({tag, "_t3"}, pick(E_BUSY_STALL, E_NORMAL));
    tick();
    #1 chk_out({tag, "_t4_we"}, pick(E_BUSY_WE, E_NORMAL));
    tick(); IF_ID_UsesHiLo = 1'b0;
    #1 chk_out({tag, "_t5"}, E_NORMAL);
  endtask

  initial begin
    // Reset held with hazardous inputs present
    rst = 1'b1;
    clear_inputs();
    ID_EX_MemRead = 1'b1; ID_EX_Reg_Rt = 5'd8; IF_ID_Reg_Rs = 5'd8;
    Branch_Taken_EX = 1'b1; MulDiv_Start_EX = 1'b1; IF_ID_UsesHiLo = 1'b1;
    #3 chk_out("rst_hold", E_NORMAL);
    tick();
    chk_out("rst_hold_edge", E_NORMAL);
    clear_inputs();
    tick();
    rst = 1'b0;
    #1 chk_out("after_rst", E_NORMAL);

    // Load-use on rs: one bubble, then normal once the load moves on
    tick(); ID_EX_MemRead = 1'b1; ID_EX_Reg_Rt = 5'd8; IF_ID_Reg_Rs = 5'd8;
    #1 chk_out("load_use_rs", E_STALL);
    tick(); ID_EX_MemRead = 1'b0;
    #1 chk_out("load_use_release", E_NORMAL);

    // Load-use on rt when rt is read
    tick(); ID_EX_MemRead = 1'b1; ID_EX_Reg_Rt = 5'd9; IF_ID_Reg_Rs = 5'd3;
    IF_ID_Reg_Rt = 5'd9; IF_ID_UsesRt = 1'b1;
    #1 chk_out("load_use_rt", E_STALL);

    // rt match but rt not read
    tick(); IF_ID_UsesRt = 1'b0;
    #1 chk_out("rt_unused", E_NORMAL);

    // Load to $0 never stalls
    tick(); ID_EX_Reg_Rt = 5'd0; IF_ID_Reg_Rs = 5'd0; IF_ID_Reg_Rt = 5'd0;
    IF_ID_UsesRt = 1'b1;
    #1 chk_out("load_r0", E_NORMAL);

    // Branch together with load-use: flush wins
    tick(); ID_EX_Reg_Rt = 5'd8; IF_ID_Reg_Rs = 5'd8; Branch_Taken_EX = 1'b1;
    #1 chk_out("branch_over_stall", E_FLUSH);

    // Plain branch
    tick(); ID_EX_MemRead = 1'b0;
    #1 chk_out("branch_only", E_FLUSH);
    tick(); clear_inputs();
    #1 chk_out("idle", E_NORMAL);

    // Mult sequencing
    tick();
    run_mult("mult");

    // Div: single pulse 32 cycles after start; restarts at T+5 and at the
    // write cycle are ignored
    tick(); MulDiv_Start_EX = 1'b1; MulDiv_IsDiv_EX = 1'b1;
    #1 chk_out("div_t0", E_NORMAL);
    pulses = 0;
    for (int i = 1; i <= 33; i++) begin
      tick();
      MulDiv_Start_EX = (i == 5) || (i == 32);
      MulDiv_IsDiv_EX = 1'b0;
      #1;
      if (HiLo_We === 1'b1) pulses++;
      if (i < 32)       chk_out($sformatf("div_t%0d", i), pick(E_BUSY_RUN, E_NORMAL));
      else if (i == 32) chk_out("div_t32_we", pick(E_BUSY_WE, E_NORMAL));
      else              chk_out("div_t33", E_NORMAL);
    end
    MulDiv_Start_EX = 1'b0;
    chk("div_pulses", 6'(pulses), pick(6'd1, 6'd0));

    // Reset in the middle of a div
    tick(); MulDiv_Start_EX = 1'b1; MulDiv_IsDiv_EX = 1'b1;
    #1 chk_out("rdiv_t0", E_NORMAL);
    tick(); MulDiv_Start_EX = 1'b0;
    #1 chk_out("rdiv_t1", pick(E_BUSY_RUN, E_NORMAL));
    tick();
    #1 chk_out("rdiv_t2", pick(E_BUSY_RUN, E_NORMAL));
    rst = 1'b1;
    ID_EX_MemRead = 1'b1; ID_EX_Reg_Rt = 5'd4; IF_ID_Reg_Rs = 5'd4; IF_ID_UsesHiLo = 1'b1;
    #1 chk_out("rst_async", E_NORMAL);
    tick();
    #1 chk_out("rst_async_hold", E_NORMAL);
    clear_inputs();
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 35; i++) begin
      tick();
      #1;
      if (HiLo_We === 1'b1 || MulDiv_Busy === 1'b1) pulses++;
    end
    chk("rst_no_we", 6'(pulses), 6'd0);

    // Full mult after reset release
    tick();
    run_mult("mult2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
